instr_fetcher: RTL and testbench
================================

# instr_fetcher

Per-core instruction fetch stage. It sits between the core scheduler and the program-memory controller and feeds the decoder; the PC stage in turn consumes the decoded result. When the scheduler enters FETCH, the block reads the 16-bit instruction at `current_pc`, either from a small direct-mapped line buffer or over the memory read handshake. It holds that instruction stable until the scheduler moves to DECODE.

## Interface
Parameters:
- `PROGRAM_MEM_ADDR_BITS`, default 8: instruction address width.
- `PROGRAM_MEM_DATA_BITS`, default 16: instruction width.
- `BUFFER_ENTRIES`, default 4: line-buffer depth. Must be a power of two, at least 2.

Ports:
- Clock and reset are fixed: one clock, `clk`; `reset` is asynchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `core_state`  in  3  scheduler state. FETCH = 3'b001, DECODE = 3'b010; all other codes mean "no request".
- `current_pc`  in  `PROGRAM_MEM_ADDR_BITS`  address to fetch. Sampled in IDLE only.
- `invalidate`  in  1  clears all line-buffer entries. Pulsed on program load.
- `mem_read_valid`  out  1  read request to program memory.
- `mem_read_address`  out  `PROGRAM_MEM_ADDR_BITS`  request address.
- `mem_read_ready`  in  1  memory response strobe. Data is valid in the same cycle.
- `mem_read_data`  in  `PROGRAM_MEM_DATA_BITS`  response data.
- `fetcher_state`  out  3  IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
- `instruction`  out  `PROGRAM_MEM_DATA_BITS`  fetched instruction. Valid while in FETCHED.

## Operation
- Buffer organisation:
  - index = `current_pc[log2(BUFFER_ENTRIES)-1:0]`.
  - tag = the remaining upper PC bits.
  - Each entry holds a valid bit, a tag and 16 data bits.
- **IDLE**, with `core_state` == FETCH:
  - Hit (valid and tag match): load `instruction` from the buffer and go to FETCHED. No memory request is issued.
  - Miss: set `mem_read_valid`=1 and `mem_read_address`=`current_pc`, and go to FETCHING.
- **IDLE**, otherwise: hold all state.
- **FETCHING**:
  - Hold `mem_read_valid` and `mem_read_address` stable until `mem_read_ready` is sampled high.
  - On that edge: capture `mem_read_data` into `instruction`, write the buffer entry (valid=1, tag, data), clear `mem_read_valid`, and go to FETCHED.
- **FETCHED**:
  - `instruction` is held constant.
  - When `core_state` == DECODE, go to IDLE.
- **`invalidate`:**
  - Clears every valid bit at the clock edge.
  - In IDLE, an `invalidate` coinciding with a FETCH request wins: the lookup is treated as a miss.
  - During FETCHING, an `invalidate` coinciding with, or preceding, the response edge means the response still updates `instruction` but is not written into the buffer.
- **Other boundary conditions:**
  - `core_state` leaving FETCH during FETCHING does not abort; the transaction completes.
  - `mem_read_ready` outside FETCHING is ignored.
  - `current_pc` changes outside IDLE are ignored.
  - No wrap-around arithmetic: the address is passed through unmodified.
- **Reset**, asynchronous at any time including mid-transaction:
  - state = IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0.
  - All buffer valid bits are 0.
  - A pending memory response after reset is ignored.

## Timing
- All outputs are registered; none combinationally depend on inputs.
- Hit: FETCH sampled at edge N → `fetcher_state`=FETCHED and `instruction` valid after edge N. Latency 1 cycle.
- Miss: FETCH sampled at edge N → `mem_read_valid` high after N. With `mem_read_ready` high at edge M (M ≥ N+1), FETCHED and `instruction` are valid after M. Minimum latency 2 cycles.
- DECODE sampled in FETCHED at edge K → IDLE after K. A new FETCH can be accepted at edge K+1 at the earliest.
- At most one outstanding memory request.

## Structure
- Shared package `fetch_pkg` holds:
  - `core_state` codes FETCH and DECODE.
  - The `fetcher_state` enum (IDLE, FETCHING, FETCHED).
  - Default address and data widths.
- Sub-module `fetch_line_buffer`:
  - Tag/valid/data array.
  - Combinational lookup port returning hit and data.
  - Synchronous write port.
  - Asynchronous reset and a synchronous `invalidate` that clears all valid bits.
- Top level contains the FSM and the handshake registers.

## Test plan
- Reset, then FETCH @pc=0x05 with memory returning 0x1234 two cycles later → `mem_read_valid`=1 with `mem_read_address`=0x05 for 2 cycles, then FETCHED with `instruction`=0x1234.
- Repeat FETCH @0x05 after DECODE → FETCHED one cycle later; `mem_read_valid` never asserts.
- Fetch 0x05 then 0x09 (same index, different tag), then 0x05 again → three memory requests. The final instruction matches the memory at 0x05.
- `invalidate` with a FETCH @0x05 after 0x05 is buffered → miss; memory request issued.
- `invalidate` during FETCHING @0x06, memory returns 0xABCD → `instruction`=0xABCD. A later FETCH @0x06 misses.
- Assert `reset` during FETCHING, then pulse `mem_read_ready` → state IDLE, `mem_read_valid`=0, `instruction`=0, and no buffer write.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: scheduler codes,
// fetcher state encoding and default bus widths.
package fetch_pkg;

  localparam int ADDR_BITS_DEFAULT = 8;
  localparam int DATA_BITS_DEFAULT = 16;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/fetch_line_buffer.sv
// Direct-mapped instruction line buffer: combinational lookup, synchronous
// write, and a synchronous invalidate that takes priority over writes.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int ENTRIES   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_invalidate,
  input  logic [ADDR_BITS-1:0] i_lookup_addr,
  output logic                 o_hit,
  output logic [DATA_BITS-1:0] o_data,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_BITS-1:0]  r_tag  [ENTRIES];
  logic [DATA_BITS-1:0] r_data [ENTRIES];

  logic [IDX_BITS-1:0] w_lookup_idx;
  logic [TAG_BITS-1:0] w_lookup_tag;
  logic [IDX_BITS-1:0] w_wr_idx;
  logic [TAG_BITS-1:0] w_wr_tag;

  assign w_lookup_idx = i_lookup_addr[IDX_BITS-1:0];
  assign w_lookup_tag = i_lookup_addr[ADDR_BITS-1:IDX_BITS];
  assign w_wr_idx     = i_wr_addr[IDX_BITS-1:0];
  assign w_wr_tag     = i_wr_addr[ADDR_BITS-1:IDX_BITS];

  assign o_hit  = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);
  assign o_data = r_data[w_lookup_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_invalidate) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is deliberately left unreset; the valid bits alone
  // decide whether an entry is trusted, so this can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch stage: serves FETCH requests from the line buffer or over
// the program-memory read handshake, holding the result until DECODE.
module instr_fetcher
  import fetch_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int PROGRAM_MEM_DATA_BITS = DATA_BITS_DEFAULT,
  parameter int BUFFER_ENTRIES        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_e                   r_state,        w_state_next;
  logic                             r_mem_valid,    w_mem_valid_next;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr,     w_mem_addr_next;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction,  w_instruction_next;
  logic                             r_inval_seen,   w_inval_seen_next;

  logic                             w_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
  logic                             w_buf_wr;

  fetch_line_buffer #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .ENTRIES   (BUFFER_ENTRIES)
  ) u_line_buffer (
    .clk           (clk),
    .reset         (reset),
    .i_invalidate  (invalidate),
    .i_lookup_addr (current_pc),
    .o_hit         (w_hit),
    .o_data        (w_hit_data),
    .i_wr_en       (w_buf_wr),
    .i_wr_addr     (r_mem_addr),
    .i_wr_data     (mem_read_data)
  );

  // NOTE: every sequential register uses non-blocking assignment so all state
  // updates at an edge see the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_instruction <= '0;
      r_inval_seen  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_mem_valid   <= w_mem_valid_next;
      r_mem_addr    <= w_mem_addr_next;
      r_instruction <= w_instruction_next;
      r_inval_seen  <= w_inval_seen_next;
    end
  end

  // NOTE: every output of this block gets a hold-value default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    w_state_next       = r_state;
    w_mem_valid_next   = r_mem_valid;
    w_mem_addr_next    = r_mem_addr;
    w_instruction_next = r_instruction;
    w_inval_seen_next  = r_inval_seen;
    w_buf_wr           = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (w_hit && !invalidate) begin
            w_instruction_next = w_hit_data;
            w_state_next       = FETCHED;
          end else begin
            w_mem_valid_next  = 1'b1;
            w_mem_addr_next   = current_pc;
            w_inval_seen_next = 1'b0;
            w_state_next      = FETCHING;
          end
        end
      end
      FETCHING: begin
        if (invalidate) w_inval_seen_next = 1'b1;
        // A response after any invalidate in this transaction may be stale
        // relative to the new program, so it is delivered but not cached.
        if (mem_read_ready) begin
          w_instruction_next = mem_read_data;
          w_buf_wr           = !(r_inval_seen || invalidate);
          w_mem_valid_next   = 1'b0;
          w_inval_seen_next  = 1'b0;
          w_state_next       = FETCHED;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_mem_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instruction;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: table of fetch vectors against a
// memory model and expected-instruction scoreboard, plus reset corner cases.
module tb_instr_fetcher;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  instr_fetcher #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .PROGRAM_MEM_DATA_BITS (16),
    .BUFFER_ENTRIES        (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .invalidate       (invalidate),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  // inv: 0 none, 1 with the FETCH request, 2 in the first FETCHING cycle
  typedef struct {
    logic [7:0] pc;
    int         lat;
    int         inv;
    bit         hit;
  } vec_t;

  vec_t        vecs [17];
  logic [15:0] mem  [256];
  logic [15:0] exp_q [$];
  logic [15:0] last_exp;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fetched(input string name);
    int k = 0;
    while (fetcher_state != FETCHED && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({name, "_reach_fetched"}, fetcher_state, FETCHED);
  endtask

  task automatic run_fetch(input vec_t v, input string name);
    core_state = CORE_FETCH;
    current_pc = v.pc;
    invalidate = (v.inv == 1);
    exp_q.push_back(mem[v.pc]);
    @(negedge clk);
    core_state = 3'b000;
    invalidate = 1'b0;
    current_pc = ~v.pc;
    if (v.hit) begin
      check({name, "_hit_state"}, fetcher_state, FETCHED);
      check({name, "_hit_no_req"}, mem_read_valid, 0);
    end else begin
      for (int i = 1; i <= v.lat; i++) begin
        check({name, "_req_state"}, fetcher_state, FETCHING);
        check({name, "_req_valid"}, mem_read_valid, 1);
        check({name, "_req_addr"}, mem_read_address, v.pc);
        if (i == 1 && v.inv == 2) invalidate = 1'b1;
        if (i == v.lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[v.pc];
        end
        @(negedge clk);
        invalidate     = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'hDEAD;
      end
    end
    wait_fetched(name);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check({name, "_instr"}, instruction, last_exp);
    end else begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end
    check({name, "_valid_clear"}, mem_read_valid, 0);
  endtask

  task automatic run_decode(input string name);
    core_state     = 3'b011;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h7777;
    current_pc     = 8'($urandom);
    @(negedge clk);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    check({name, "_hold_state"}, fetcher_state, FETCHED);
    check({name, "_hold_instr"}, instruction, last_exp);
    core_state = CORE_DECODE;
    @(negedge clk);
    core_state = 3'b000;
    check({name, "_decode_idle"}, fetcher_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h3C, 8'(i)};
    mem[8'h05] = 16'h1234;
    mem[8'h06] = 16'hABCD;
    mem[8'h09] = 16'h5A5A;

    vecs[0]  = '{8'h05, 2, 0, 1'b0};
    vecs[1]  = '{8'h05, 1, 0, 1'b1};
    vecs[2]  = '{8'h09, 1, 0, 1'b0};
    vecs[3]  = '{8'h05, 3, 0, 1'b0};
    vecs[4]  = '{8'h05, 1, 0, 1'b1};
    vecs[5]  = '{8'h05, 1, 1, 1'b0};
    vecs[6]  = '{8'h05, 1, 0, 1'b1};
    vecs[7]  = '{8'h06, 2, 2, 1'b0};
    vecs[8]  = '{8'h06, 1, 0, 1'b0};
    vecs[9]  = '{8'h06, 1, 0, 1'b1};
    vecs[10] = '{8'h0A, 1, 2, 1'b0};
    vecs[11] = '{8'h0A, 1, 0, 1'b0};
    vecs[12] = '{8'hFF, 1, 0, 1'b0};
    vecs[13] = '{8'hFF, 1, 0, 1'b1};
    vecs[14] = '{8'h00, 2, 0, 1'b0};
    vecs[15] = '{8'h0A, 1, 0, 1'b1};
    vecs[16] = '{8'h06, 1, 0, 1'b0};

    reset          = 1'b1;
    core_state     = 3'b000;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    last_exp       = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_state", fetcher_state, IDLE);
    check("rst_valid", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_instr", instruction, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 17; n++) begin
      run_fetch(vecs[n], $sformatf("v%0d", n));
      run_decode($sformatf("v%0d", n));
    end

    // Reset in the middle of a memory transaction, then a stray response.
    core_state = CORE_FETCH;
    current_pc = 8'h07;
    @(negedge clk);
    core_state = 3'b000;
    check("mid_rst_req_valid", mem_read_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", fetcher_state, IDLE);
    check("mid_rst_valid", mem_read_valid, 0);
    check("mid_rst_addr", mem_read_address, 0);
    check("mid_rst_instr", instruction, 0);
    @(negedge clk);
    reset          = 1'b0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    check("stray_rsp_state", fetcher_state, IDLE);
    check("stray_rsp_instr", instruction, 0);
    check("stray_rsp_valid", mem_read_valid, 0);

    // Buffer was cleared by reset and the stray response must not fill it.
    run_fetch('{8'hFF, 1, 0, 1'b0}, "post_rst_ff");
    run_decode("post_rst_ff");
    run_fetch('{8'h07, 2, 0, 1'b0}, "post_rst_07");
    run_decode("post_rst_07");
    run_fetch('{8'h07, 1, 0, 1'b1}, "post_rst_07_hit");
    run_decode("post_rst_07_hit");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
